// File: rtl/proc_csr_io_pkg.sv
// Shared defaults and the channel-select width helper for the CSR I/O unit.
package proc_csr_io_pkg;

   localparam int NUM_IN_DEF  = 3;
   localparam int NUM_OUT_DEF = 3;
   localparam int W_DEF       = 32;
   localparam int DEPTH_DEF   = 3;

   // Select width wide enough for the larger channel count, never zero.
   function automatic int sel_width(input int n_in, input int n_out);
      int n;
      n = (n_in > n_out) ? n_in : n_out;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/proc_csr_io_stage.sv
// One in-flight CSR write slot {val, sel, data}; en holds when low, clr drops the entry.
module proc_csr_io_stage #(
   parameter int SELW = 2,
   parameter int W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic            d_val,
   input  logic [SELW-1:0] d_sel,
   input  logic [W-1:0]    d_data,
   output logic            q_val,
   output logic [SELW-1:0] q_sel,
   output logic [W-1:0]    q_data
);

   logic            val_d, val_q;
   logic [SELW-1:0] sel_d, sel_q;
   logic [W-1:0]    data_d, data_q;

   always_comb begin
      val_d  = val_q;
      sel_d  = sel_q;
      data_d = data_q;
      if (en) begin
         val_d  = d_val;
         sel_d  = d_sel;
         data_d = d_data;
      end
      if (clr) val_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) val_q <= 1'b0;
      else      val_q <= val_d;
   end

   // NOTE: the payload is left unreset on purpose; val gates every use of it.
   always_ff @(posedge clk) begin
      sel_q  <= sel_d;
      data_q <= data_d;
   end

   assign q_val  = val_q;
   assign q_sel  = sel_q;
   assign q_data = data_q;

endmodule

// File: rtl/proc_csr_io.sv
// CSR I/O unit: sampled reads, pipelined writes committing at writeback, hazard status.
module proc_csr_io
   import proc_csr_io_pkg::*;
#(
   parameter int NUM_IN  = NUM_IN_DEF,
   parameter int NUM_OUT = NUM_OUT_DEF,
   parameter int W       = W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int SELW    = sel_width(NUM_IN, NUM_OUT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_IN*W-1:0]  in,
   output logic [NUM_OUT*W-1:0] out,
   output logic [NUM_OUT-1:0]   out_upd,
   input  logic                 rd_val,
   input  logic [SELW-1:0]      rd_sel,
   output logic [W-1:0]         rd_data,
   output logic                 rd_err,
   input  logic                 wr_val,
   input  logic [SELW-1:0]      wr_sel,
   input  logic [W-1:0]         wr_data,
   output logic                 wr_err,
   input  logic                 stall,
   input  logic [DEPTH-1:0]     kill,
   output logic [NUM_OUT-1:0]   pending,
   output logic                 busy
);

   localparam logic [SELW:0] NUM_IN_L  = NUM_IN[SELW:0];
   localparam logic [SELW:0] NUM_OUT_L = NUM_OUT[SELW:0];

   logic            st_val  [DEPTH];
   logic [SELW-1:0] st_sel  [DEPTH];
   logic [W-1:0]    st_data [DEPTH];
   logic            nx_val  [DEPTH];
   logic [SELW-1:0] nx_sel  [DEPTH];
   logic [W-1:0]    nx_data [DEPTH];
   logic            wr_ok;
   logic            commit;

   always_comb begin
      wr_ok      = wr_val && !stall && ({1'b0, wr_sel} < NUM_OUT_L);
      nx_val[0]  = wr_ok;
      nx_sel[0]  = wr_sel;
      nx_data[0] = wr_data;
      // An entry killed in stage i-1 must not propagate into stage i.
      for (int i = 1; i < DEPTH; i++) begin
         nx_val[i]  = st_val[i-1] && !kill[i-1];
         nx_sel[i]  = st_sel[i-1];
         nx_data[i] = st_data[i-1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      proc_csr_io_stage #(
         .SELW(SELW),
         .W   (W)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en    (!stall),
         .clr   (kill[i]),
         .d_val (nx_val[i]),
         .d_sel (nx_sel[i]),
         .d_data(nx_data[i]),
         .q_val (st_val[i]),
         .q_sel (st_sel[i]),
         .q_data(st_data[i])
      );
   end

   assign commit = !stall && st_val[DEPTH-1] && !kill[DEPTH-1];

   logic [NUM_OUT*W-1:0] out_d, out_q;
   logic [NUM_OUT-1:0]   out_upd_d, out_upd_q;
   logic [W-1:0]         rd_data_d, rd_data_q;
   logic                 rd_err_d, rd_err_q;
   logic                 wr_err_d, wr_err_q;

   always_comb begin
      out_d     = out_q;
      out_upd_d = '0;
      for (int c = 0; c < NUM_OUT; c++) begin
         if (commit && st_sel[DEPTH-1] == c[SELW-1:0]) begin
            out_d[c*W +: W] = st_data[DEPTH-1];
            out_upd_d[c]    = 1'b1;
         end
      end

      rd_data_d = '0;
      rd_err_d  = 1'b0;
      if (rd_val) begin
         if ({1'b0, rd_sel} < NUM_IN_L) begin
            for (int k = 0; k < NUM_IN; k++) begin
               if (rd_sel == k[SELW-1:0]) rd_data_d = in[k*W +: W];
            end
         end else begin
            rd_err_d = 1'b1;
         end
      end

      wr_err_d = wr_val && !stall && !({1'b0, wr_sel} < NUM_OUT_L);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_q     <= '0;
         out_upd_q <= '0;
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_upd_q <= out_upd_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
         wr_err_q  <= wr_err_d;
      end
   end

   always_comb begin
      pending = '0;
      busy    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         busy = busy || st_val[i];
         for (int c = 0; c < NUM_OUT; c++) begin
            if (st_val[i] && st_sel[i] == c[SELW-1:0]) pending[c] = 1'b1;
         end
      end
   end

   assign out     = out_q;
   assign out_upd = out_upd_q;
   assign rd_data = rd_data_q;
   assign rd_err  = rd_err_q;
   assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_proc_csr_io.sv
// Directed bench for proc_csr_io: default instance plus a NUM_OUT=5, W=16 variant.
module tb_proc_csr_io;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // Default instance (3 in, 3 out, 32-bit, depth 3, SELW=2)
   logic [95:0] in_bus;
   logic [95:0] out_bus;
   logic [2:0]  out_upd;
   logic        rd_val, rd_err, wr_val, wr_err, stall, busy;
   logic [1:0]  rd_sel, wr_sel;
   logic [31:0] rd_data, wr_data;
   logic [2:0]  kill, pending;

   proc_csr_io u_dut (
      .clk(clk), .rst(rst), .in(in_bus), .out(out_bus), .out_upd(out_upd),
      .rd_val(rd_val), .rd_sel(rd_sel), .rd_data(rd_data), .rd_err(rd_err),
      .wr_val(wr_val), .wr_sel(wr_sel), .wr_data(wr_data), .wr_err(wr_err),
      .stall(stall), .kill(kill), .pending(pending), .busy(busy)
   );

   // Variant instance (3 in, 5 out, 16-bit, SELW=3)
   logic [47:0] v_in;
   logic [79:0] v_out;
   logic [4:0]  v_out_upd, v_pending;
   logic        v_rd_val, v_rd_err, v_wr_val, v_wr_err, v_stall, v_busy;
   logic [2:0]  v_rd_sel, v_wr_sel, v_kill;
   logic [15:0] v_rd_data, v_wr_data;

   proc_csr_io #(.NUM_OUT(5), .W(16)) u_dut5 (
      .clk(clk), .rst(rst), .in(v_in), .out(v_out), .out_upd(v_out_upd),
      .rd_val(v_rd_val), .rd_sel(v_rd_sel), .rd_data(v_rd_data), .rd_err(v_rd_err),
      .wr_val(v_wr_val), .wr_sel(v_wr_sel), .wr_data(v_wr_data), .wr_err(v_wr_err),
      .stall(v_stall), .kill(v_kill), .pending(v_pending), .busy(v_busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] sel, input logic [31:0] data);
      wr_val  = 1'b1;
      wr_sel  = sel;
      wr_data = data;
   endtask

   typedef struct {
      logic        rd_val;
      logic [1:0]  rd_sel;
      logic        wr_val;
      logic [1:0]  wr_sel;
      logic [31:0] exp_rd;
      logic        exp_rd_err;
      logic        exp_wr_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b1, 2'd1, 1'b0, 2'd0, 32'd6, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 2'd3, 1'b1, 2'd3, 32'd0, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 2'd0, 1'b0, 2'd3, 32'd5, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 2'd2, 1'b0, 2'd0, 32'd7, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 2'd1, 1'b1, 2'd3, 32'd0, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 2'd3, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0};

      rst = 1'b0;
      in_bus = {32'd7, 32'd6, 32'd5};
      rd_val = 0; rd_sel = 0; wr_val = 0; wr_sel = 0; wr_data = 0; stall = 0; kill = 0;
      v_in = {16'h0C0D, 16'h0B0B, 16'h0A0A};
      v_rd_val = 0; v_rd_sel = 0; v_wr_val = 0; v_wr_sel = 0; v_wr_data = 0;
      v_stall = 0; v_kill = 0;
      tick();
      tick();

      // Reset state
      check("rst_out", out_bus, 0);
      check("rst_out_upd", out_upd, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_err", rd_err, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_busy", busy, 0);
      check("rst_pending", pending, 0);
      check("rst_v_out", v_out, 0);
      check("rst_v_busy", v_busy, 0);
      rst = 1'b1;
      tick();

      // Read path and out-of-range write drop, one cycle each
      for (int i = 0; i < 6; i++) begin
         rd_val = vecs[i].rd_val;
         rd_sel = vecs[i].rd_sel;
         wr_val = vecs[i].wr_val;
         wr_sel = vecs[i].wr_sel;
         wr_data = 32'hDEAD_0000 + i;
         tick();
         check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_rd_err", i), rd_err, vecs[i].exp_rd_err);
         check($sformatf("vec%0d_wr_err", i), wr_err, vecs[i].exp_wr_err);
         check($sformatf("vec%0d_busy", i), busy, 0);
      end
      rd_val = 0; wr_val = 0;
      tick();

      // Single write to ch2, read of index 2 alongside (no forwarding)
      issue(2'd2, 32'hAB);
      rd_val = 1; rd_sel = 2'd2;
      tick();
      wr_val = 0; rd_val = 0;
      check("a_rd_no_fwd", rd_data, 32'd7);
      check("a_pend_t1", pending, 3'b100);
      check("a_busy_t1", busy, 1);
      tick();
      check("a_pend_t2", pending, 3'b100);
      tick();
      check("a_pend_t3", pending, 3'b100);
      check("a_out2_t3", out_bus[64 +: 32], 0);
      check("a_upd_t3", out_upd, 0);
      tick();
      check("a_out2_t4", out_bus[64 +: 32], 32'hAB);
      check("a_upd_t4", out_upd, 3'b100);
      check("a_pend_t4", pending, 0);
      check("a_busy_t4", busy, 0);
      tick();
      check("a_upd_t5", out_upd, 0);

      // Back-to-back writes: ch0=1, ch0=2, ch1=3
      issue(2'd0, 32'd1); tick();
      check("b_pend_t1", pending, 3'b001);
      issue(2'd0, 32'd2); tick();
      issue(2'd1, 32'd3); tick();
      wr_val = 0;
      check("b_pend_t3", pending, 3'b011);
      tick();
      check("b_out0_t4", out_bus[0 +: 32], 32'd1);
      check("b_upd_t4", out_upd, 3'b001);
      check("b_pend_t4", pending, 3'b011);
      tick();
      check("b_out0_t5", out_bus[0 +: 32], 32'd2);
      check("b_upd_t5", out_upd, 3'b001);
      check("b_pend_t5", pending, 3'b010);
      tick();
      check("b_out1_t6", out_bus[32 +: 32], 32'd3);
      check("b_upd_t6", out_upd, 3'b010);
      check("b_pend_t6", pending, 0);

      // Write ch1, stall during t+2..t+3, write attempted during stall ignored
      issue(2'd1, 32'h55); tick();
      wr_val = 0; tick();
      stall = 1; issue(2'd0, 32'h99); tick();
      check("c_upd_stall", out_upd, 0);
      check("c_busy_stall", busy, 1);
      tick();
      stall = 0; wr_val = 0;
      check("c_pend_t4", pending, 3'b010);
      check("c_wr_err_stall", wr_err, 0);
      tick();
      check("c_out1_t5", out_bus[32 +: 32], 32'd3);
      check("c_upd_t5", out_upd, 0);
      tick();
      check("c_out1_t6", out_bus[32 +: 32], 32'h55);
      check("c_upd_t6", out_upd, 3'b010);
      tick();
      check("c_busy_after", busy, 0);
      check("c_out0_kept", out_bus[0 +: 32], 32'd2);

      // kill[1] on a write to ch0
      issue(2'd0, 32'hDD); tick();
      wr_val = 0; tick();
      kill = 3'b010; tick();
      kill = 0;
      check("d_pend_kill1", pending, 0);
      check("d_busy_kill1", busy, 0);
      tick(); tick(); tick();
      check("d_out0_kept", out_bus[0 +: 32], 32'd2);
      check("d_upd_none", out_upd, 0);

      // kill[0] while stalled
      issue(2'd2, 32'hEE); tick();
      wr_val = 0; stall = 1; tick();
      kill = 3'b001; tick();
      stall = 0; kill = 0;
      check("d_busy_kill_stall", busy, 0);
      tick(); tick(); tick(); tick();
      check("d_out2_kept", out_bus[64 +: 32], 32'hAB);

      // kill on the last stage blocks the commit
      issue(2'd1, 32'h77); tick();
      wr_val = 0; tick(); tick();
      kill = 3'b100; tick();
      kill = 0;
      check("d_out1_kill2", out_bus[32 +: 32], 32'h55);
      check("d_upd_kill2", out_upd, 0);
      check("d_busy_kill2", busy, 0);

      // NUM_OUT=5, W=16 variant
      v_wr_val = 1; v_wr_sel = 3'd4; v_wr_data = 16'hBEEF; tick();
      v_wr_sel = 3'd5; v_rd_val = 1; v_rd_sel = 3'd3; tick();
      v_wr_val = 0;
      check("v_wr_err", v_wr_err, 1);
      check("v_rd_err", v_rd_err, 1);
      check("v_rd_data_oor", v_rd_data, 0);
      check("v_pend", v_pending, 5'b10000);
      v_rd_sel = 3'd2; tick();
      v_rd_val = 0;
      check("v_rd_data", v_rd_data, 16'h0C0D);
      check("v_wr_err_clear", v_wr_err, 0);
      tick();
      check("v_out4", v_out[64 +: 16], 16'hBEEF);
      check("v_upd", v_out_upd, 5'b10000);
      check("v_busy", v_busy, 0);

      // Reset with three writes in flight
      issue(2'd0, 32'h11); tick();
      issue(2'd1, 32'h22); tick();
      issue(2'd2, 32'h33); tick();
      wr_val = 0; rst = 0; tick();
      check("e_busy", busy, 0);
      check("e_out", out_bus, 0);
      check("e_pend", pending, 0);
      check("e_v_out", v_out, 0);
      rst = 1;
      tick(); tick(); tick(); tick();
      check("e_out_later", out_bus, 0);
      check("e_upd_later", out_upd, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
